// File: rtl/pong_ball_ctrl.sv
// rtl/pong_ball_ctrl.sv - Pong ball motion engine: serve countdown, wall/paddle bounces, misses, score pulses.
// Optional PONG_SPEEDUP_EN: horizontal step grows by one per paddle hit up to 2*SPEED.
module pong_ball_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_L_X  = 16,
  parameter int PADDLE_R_X  = 616,
  parameter int SPEED       = 2,
  parameter int SERVE_TICKS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       score_l_inc,
  output logic       score_r_inc,
  output logic       playing
);

  typedef enum logic [1:0] {IDLE, SERVE, PLAY} state_t;

  localparam int CW = $clog2(SERVE_TICKS + 1);
  localparam logic [9:0]        CX     = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]        CY     = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [10:0] SP    = 11'(SPEED);
  localparam logic signed [10:0] L_FACE = 11'(PADDLE_L_X + PADDLE_W);
  localparam logic signed [10:0] R_FACE = 11'(PADDLE_R_X - BALL_SIZE);
  localparam logic signed [10:0] X_MAX = 11'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [10:0] Y_MAX = 11'(V_ACTIVE - BALL_SIZE);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dx;  // 1 = moving right
  logic          dy;  // 1 = moving down

`ifdef PONG_SPEEDUP_EN
  localparam logic signed [10:0] SP2 = 11'(2 * SPEED);
  logic signed [10:0] hs;
`else
  logic signed [10:0] hs;
  assign hs = SP;
`endif

  logic signed [10:0] sx, sy, nx, ny;
  logic [10:0]        by_ext, pl_ext, pr_ext;
  logic               ndy, ovl_l, ovl_r, hit_l, hit_r, miss_l, miss_r;

  assign sx     = $signed({1'b0, ball_x});
  assign sy     = $signed({1'b0, ball_y});
  assign by_ext = {1'b0, ball_y};
  assign pl_ext = {1'b0, paddle_l_y};
  assign pr_ext = {1'b0, paddle_r_y};

  always_comb begin
    ny  = sy;
    ndy = dy;
    if (dy && (sy + SP >= Y_MAX)) begin
      ny  = Y_MAX;
      ndy = 1'b0;
    end else if (!dy && (sy < SP)) begin
      ny  = '0;
      ndy = 1'b1;
    end else begin
      ny = dy ? sy + SP : sy - SP;
    end

    ovl_l  = (by_ext + 11'(BALL_SIZE) > pl_ext) && (by_ext < pl_ext + 11'(PADDLE_H));
    ovl_r  = (by_ext + 11'(BALL_SIZE) > pr_ext) && (by_ext < pr_ext + 11'(PADDLE_H));
    hit_l  = !dx && (sx >= L_FACE) && (sx - hs <= L_FACE) && ovl_l;
    hit_r  = dx && (sx <= R_FACE) && (sx + hs >= R_FACE) && ovl_r;
    miss_l = !dx && (sx < hs);
    miss_r = dx && (sx + hs >= X_MAX);

    if (hit_l)      nx = L_FACE;
    else if (hit_r) nx = R_FACE;
    else            nx = dx ? sx + hs : sx - hs;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ball_x      <= CX;
      ball_y      <= CY;
      dx          <= 1'b1;
      dy          <= 1'b1;
      score_l_inc <= 1'b0;
      score_r_inc <= 1'b0;
      playing     <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      hs          <= SP;
`endif
    end else begin
      score_l_inc <= 1'b0;
      score_r_inc <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= SERVE;
            cnt     <= CW'(SERVE_TICKS);
            playing <= 1'b1;
          end
        end
        SERVE: begin
          if (tick) begin
            if (cnt == CW'(1)) state <= PLAY;
            cnt <= cnt - CW'(1);
          end
        end
        PLAY: begin
          if (tick) begin
            // a paddle hit wins over a miss; the wall bounce still applies
            if (hit_l || hit_r) begin
              ball_x <= 10'(nx);
              ball_y <= 10'(ny);
              dx     <= hit_l;
              dy     <= ndy;
`ifdef PONG_SPEEDUP_EN
              if (hs < SP2) hs <= hs + 11'sd1;
`endif
            end else if (miss_l || miss_r) begin
              score_r_inc <= miss_l;
              score_l_inc <= miss_r;
              ball_x      <= CX;
              ball_y      <= CY;
              dx          <= miss_l;
              state       <= SERVE;
              cnt         <= CW'(SERVE_TICKS);
`ifdef PONG_SPEEDUP_EN
              hs          <= SP;
`endif
            end else begin
              ball_x <= 10'(nx);
              ball_y <= 10'(ny);
              dy     <= ndy;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb/tb_pong_ball_ctrl.sv - directed self-checking bench for pong_ball_ctrl (default build).
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [9:0] paddle_l_y = '0;
  logic [9:0] paddle_r_y = '0;
  logic [9:0] ball_x, ball_y;
  logic       score_l_inc, score_r_inc, playing;

  int checks = 0;
  int failures = 0;
  int n = 0;

  pong_ball_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .start(start),
    .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .ball_x(ball_x), .ball_y(ball_y),
    .score_l_inc(score_l_inc), .score_r_inc(score_r_inc), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic do_tick();
    @(negedge clk);
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic play_to(input int target);
    while (n < target) begin
      do_tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(316,236)", ball_x, ball_y); end
    checks++; if ({playing, score_l_inc, score_r_inc} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {playing, score_l_inc, score_r_inc}); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_idle_ticks();
    repeat (10) do_tick();
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL idle_pos got=(%0d,%0d) exp=(316,236)", ball_x, ball_y); end
    checks++; if ({playing, score_l_inc, score_r_inc} !== 3'b000) begin failures++; $display("FAIL idle_flags got=%b exp=000", {playing, score_l_inc, score_r_inc}); end
  endtask

  task automatic test_serve();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (playing !== 1'b1) begin failures++; $display("FAIL serve_playing got=%b exp=1", playing); end
    repeat (99) do_tick();
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL serve_99_pos got=(%0d,%0d) exp=(316,236)", ball_x, ball_y); end
    do_tick();
    checks++; if ({ball_x, ball_y, playing} !== {10'd316, 10'd236, 1'b1}) begin failures++; $display("FAIL serve_100 got=(%0d,%0d,%b) exp=(316,236,1)", ball_x, ball_y, playing); end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    play_to(1);
    checks++; if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin failures++; $display("FAIL first_move got=(%0d,%0d) exp=(318,238)", ball_x, ball_y); end
  endtask

  task automatic test_wall_bounce();
    play_to(117);
    checks++; if ({ball_x, ball_y} !== {10'd550, 10'd470}) begin failures++; $display("FAIL bottom_pre got=(%0d,%0d) exp=(550,470)", ball_x, ball_y); end
    play_to(118);
    checks++; if ({ball_x, ball_y} !== {10'd552, 10'd472}) begin failures++; $display("FAIL bottom_clamp got=(%0d,%0d) exp=(552,472)", ball_x, ball_y); end
    play_to(119);
    checks++; if ({ball_x, ball_y} !== {10'd554, 10'd470}) begin failures++; $display("FAIL bottom_up got=(%0d,%0d) exp=(554,470)", ball_x, ball_y); end
  endtask

  task automatic test_right_paddle();
    paddle_r_y = 10'd400;
    paddle_l_y = 10'd150;
    play_to(145);
    checks++; if ({ball_x, ball_y} !== {10'd606, 10'd418}) begin failures++; $display("FAIL rpad_pre got=(%0d,%0d) exp=(606,418)", ball_x, ball_y); end
    play_to(146);
    checks++; if ({ball_x, ball_y} !== {10'd608, 10'd416}) begin failures++; $display("FAIL rpad_hit got=(%0d,%0d) exp=(608,416)", ball_x, ball_y); end
    play_to(147);
    checks++; if ({ball_x, ball_y} !== {10'd606, 10'd414}) begin failures++; $display("FAIL rpad_away got=(%0d,%0d) exp=(606,414)", ball_x, ball_y); end
  endtask

  task automatic test_top_wall();
    play_to(354);
    checks++; if ({ball_x, ball_y} !== {10'd192, 10'd0}) begin failures++; $display("FAIL top_reach got=(%0d,%0d) exp=(192,0)", ball_x, ball_y); end
    play_to(355);
    checks++; if ({ball_x, ball_y} !== {10'd190, 10'd0}) begin failures++; $display("FAIL top_turn got=(%0d,%0d) exp=(190,0)", ball_x, ball_y); end
    play_to(356);
    checks++; if ({ball_x, ball_y} !== {10'd188, 10'd2}) begin failures++; $display("FAIL top_down got=(%0d,%0d) exp=(188,2)", ball_x, ball_y); end
  endtask

  task automatic test_left_paddle();
    play_to(437);
    checks++; if ({ball_x, ball_y} !== {10'd26, 10'd164}) begin failures++; $display("FAIL lpad_pre got=(%0d,%0d) exp=(26,164)", ball_x, ball_y); end
    play_to(438);
    checks++; if ({ball_x, ball_y} !== {10'd24, 10'd166}) begin failures++; $display("FAIL lpad_hit got=(%0d,%0d) exp=(24,166)", ball_x, ball_y); end
    play_to(439);
    checks++; if ({ball_x, ball_y} !== {10'd26, 10'd168}) begin failures++; $display("FAIL lpad_away got=(%0d,%0d) exp=(26,168)", ball_x, ball_y); end
  endtask

  task automatic test_miss_right();
    paddle_r_y = 10'd0;
    play_to(729);
    checks++; if ({ball_x, ball_y} !== {10'd606, 10'd196}) begin failures++; $display("FAIL rmiss_pass got=(%0d,%0d) exp=(606,196)", ball_x, ball_y); end
    play_to(741);
    checks++; if ({ball_x, ball_y} !== {10'd630, 10'd172}) begin failures++; $display("FAIL rmiss_edge got=(%0d,%0d) exp=(630,172)", ball_x, ball_y); end
    play_to(742);
    checks++; if ({score_l_inc, score_r_inc} !== 2'b10) begin failures++; $display("FAIL rmiss_pulse got=%b exp=10", {score_l_inc, score_r_inc}); end
    checks++; if ({ball_x, ball_y, playing} !== {10'd316, 10'd236, 1'b1}) begin failures++; $display("FAIL rmiss_centre got=(%0d,%0d,%b) exp=(316,236,1)", ball_x, ball_y, playing); end
    @(posedge clk); #1;
    checks++; if ({score_l_inc, score_r_inc} !== 2'b00) begin failures++; $display("FAIL rmiss_pulse_width got=%b exp=00", {score_l_inc, score_r_inc}); end
  endtask

  task automatic test_serve_after_miss();
    repeat (99) do_tick();
    checks++; if ({ball_x, ball_y, score_l_inc, score_r_inc} !== {10'd316, 10'd236, 2'b00}) begin failures++; $display("FAIL reserve_hold got=(%0d,%0d,%b) exp=(316,236,00)", ball_x, ball_y, {score_l_inc, score_r_inc}); end
    do_tick();
    n = 0;
    play_to(1);
    checks++; if ({ball_x, ball_y} !== {10'd314, 10'd234}) begin failures++; $display("FAIL reserve_dir got=(%0d,%0d) exp=(314,234)", ball_x, ball_y); end
  endtask

  task automatic test_miss_left();
    paddle_l_y = 10'd300;
    play_to(158);
    checks++; if ({ball_x, ball_y} !== {10'd0, 10'd78}) begin failures++; $display("FAIL lmiss_edge got=(%0d,%0d) exp=(0,78)", ball_x, ball_y); end
    play_to(159);
    checks++; if ({score_l_inc, score_r_inc} !== 2'b01) begin failures++; $display("FAIL lmiss_pulse got=%b exp=01", {score_l_inc, score_r_inc}); end
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL lmiss_centre got=(%0d,%0d) exp=(316,236)", ball_x, ball_y); end
    @(posedge clk); #1;
    checks++; if ({score_l_inc, score_r_inc} !== 2'b00) begin failures++; $display("FAIL lmiss_pulse_width got=%b exp=00", {score_l_inc, score_r_inc}); end
    repeat (100) do_tick();
    n = 0;
    play_to(1);
    checks++; if ({ball_x, ball_y} !== {10'd318, 10'd238}) begin failures++; $display("FAIL lmiss_serve_dir got=(%0d,%0d) exp=(318,238)", ball_x, ball_y); end
  endtask

  task automatic test_reset_mid_game();
    play_to(5);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({ball_x, ball_y} !== {10'd316, 10'd236}) begin failures++; $display("FAIL midreset_pos got=(%0d,%0d) exp=(316,236)", ball_x, ball_y); end
    checks++; if ({playing, score_l_inc, score_r_inc} !== 3'b000) begin failures++; $display("FAIL midreset_flags got=%b exp=000", {playing, score_l_inc, score_r_inc}); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) do_tick();
    checks++; if ({ball_x, ball_y, playing} !== {10'd316, 10'd236, 1'b0}) begin failures++; $display("FAIL midreset_idle got=(%0d,%0d,%b) exp=(316,236,0)", ball_x, ball_y, playing); end
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_serve();
    test_wall_bounce();
    test_right_paddle();
    test_top_wall();
    test_left_paddle();
    test_miss_right();
    test_serve_after_miss();
    test_miss_left();
    test_reset_mid_game();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
